scene_query: RTL and testbench
==============================

SCENE_QUERY -- requirements
Module: scene_query

Interface
REQ-001 Parameter SPHERE_CX, default 32'h00000000, sphere centre x (Q8.24).
REQ-002 Parameter SPHERE_CY, default 32'h01000000, sphere centre y (1.0).
REQ-003 Parameter SPHERE_CZ, default 32'h06000000, sphere centre z (6.0).
REQ-004 Parameter SPHERE_R, default 32'h01000000, sphere radius (1.0).
REQ-005 Parameter PLANE_Y, default 32'h00000000, ground-plane height.
REQ-006 clk  input  1  rising-edge clock; the block has one clock.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 pos  input  96 (vec3: x, y, z, each fp)  query point.
REQ-009 in_valid  input  1  pos is valid this cycle.
REQ-010 closestDistance  output  32 (fp)  signed distance to nearest scene surface.
REQ-011 out_valid  output  1  closestDistance corresponds to a valid input.

Function
REQ-012 All fp values SHALL be signed two's-complement Q8.24, 32 bits wide; 1.0 = 32'h01000000; range -128 to +128-2^-24.
REQ-013 The scene SHALL be the union of one sphere and one horizontal plane; result = min(sphereDist, planeDist), using signed compare; on a tie the common value is output.
REQ-014 planeDist SHALL be pos.y - PLANE_Y, saturated to the Q8.24 range.
REQ-015 Stage 1: dx, dy, dz = pos - centre per axis, each saturated to 32'h80000000 / 32'h7FFFFFFF.
REQ-016 Stage 2: dx², dy², dz² as full 64-bit unsigned products (Q16.48).
REQ-017 Stage 3: S = dx²+dy²+dz² in 66 bits unsigned, with no truncation.
REQ-018 Sqrt stages: q = floor(sqrt(S)) exact integer square root, 33-bit result (Q8.24 scale).
  - Digit-by-digit, 2 result bits per pipeline stage, 17 stages.
REQ-019 If q > 32'h7FFFFFFF, it SHALL saturate to 32'h7FFFFFFF.
REQ-020 sphereDist = q - SPHERE_R, saturated.
REQ-021 The final stage SHALL register the min result into closestDistance.
REQ-022 Latency SHALL be exactly 21 clock cycles from the in_valid sample edge to out_valid/closestDistance.
REQ-023 Fully pipelined: one query accepted every cycle, no stall, no backpressure, results in input order.
REQ-024 plane path data SHALL be delay-matched to the sphere path.
REQ-025 in_valid SHALL propagate as a 21-deep valid shift chain to out_valid.
REQ-026 When out_valid = 0, closestDistance SHALL hold its last valid value.
REQ-027 pos SHALL be sampled only when in_valid = 1; data when in_valid = 0 has no effect on outputs.

Reset
REQ-028 While rst = 1, asynchronously: all valid bits = 0, out_valid = 0, closestDistance = 32'h00000000.
REQ-029 Queries in flight when rst asserts SHALL be discarded; no out_valid pulse for them after release.
REQ-030 The first query accepted after rst deasserts SHALL emerge exactly 21 cycles later.
REQ-031 Internal data registers other than outputs and valid bits need not be reset.

Verification
REQ-032 pos=(0,1,6) -> closestDistance 32'hFF000000 (-1.0), out_valid exactly 21 cycles after input.
REQ-033 pos=(0,0,0) -> 32'h00000000 (plane wins, sphere ≈5.083); pos=(0,1,0) -> 32'h01000000.
REQ-034 Tie case: pos=(0,4,2) gives sqrt 5, sphere 4.0, plane 4.0 -> 32'h04000000; pos=(0,5,6) -> 32'h03000000.
REQ-035 Saturation: pos=(32'h80000000, 32'h7F000000, 32'h80000000) -> dz saturates, q saturates -> 32'h7EFFFFFF.
REQ-036 Pipeline and reset:
  - Stream the four REQ-033/034 vectors back-to-back, then gap cycles -> outputs appear in order on consecutive cycles 21 after each.
  - Assert rst mid-stream -> outputs clear immediately, no stale out_valid afterwards.

Source files
------------

// File: rtl/scene_query_if.sv
// Query/result bus for scene_query: a query point goes in, a signed distance comes out.
// pos packs the query vector as {x, y, z}: x = pos[95:64], y = pos[63:32], z = pos[31:0],
// each signed Q8.24.
interface scene_query_if;
  logic [95:0] pos;
  logic        in_valid;
  logic [31:0] closestDistance;
  logic        out_valid;

  modport master (output pos, output in_valid, input closestDistance, input out_valid);
  modport slave  (input pos, input in_valid, output closestDistance, output out_valid);
endinterface

// File: rtl/scene_query.sv
// scene_query: signed distance from a query point to a sphere-plus-ground-plane scene.
// Fully pipelined, 21 register stages: subtract, square, sum, 17 sqrt stages, min/output.
module scene_query #(
  parameter logic [31:0] SPHERE_CX = 32'h00000000,
  parameter logic [31:0] SPHERE_CY = 32'h01000000,
  parameter logic [31:0] SPHERE_CZ = 32'h06000000,
  parameter logic [31:0] SPHERE_R  = 32'h01000000,
  parameter logic [31:0] PLANE_Y   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  scene_query_if.slave bus
);

  // Square-root pipeline state: radicand bits still to consume, partial remainder, partial root.
  typedef struct packed {
    logic [67:0] rad;
    logic [35:0] rem;
    logic [33:0] root;
  } sqrt_t;

  // Signed Q8.24 subtraction clamped to the representable range.
  function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
    logic signed [32:0] d;
    d = 33'(a) - 33'(b);
    if (d[32] != d[31]) return d[32] ? 32'sh80000000 : 32'sh7FFFFFFF;
    return d[31:0];
  endfunction

  // One restoring digit of the binary square root: brings in two radicand bits, yields one root bit.
  function automatic sqrt_t sqrt_iter(input sqrt_t s);
    sqrt_t       o;
    logic [35:0] r;
    logic [35:0] t;
    r = {s.rem[33:0], s.rad[67:66]};
    t = {s.root, 2'b01};
    o.rad = {s.rad[65:0], 2'b00};
    if (r >= t) begin
      o.rem  = r - t;
      o.root = {s.root[32:0], 1'b1};
    end else begin
      o.rem  = r;
      o.root = {s.root[32:0], 1'b0};
    end
    return o;
  endfunction

  logic signed [31:0] dx, dy, dz;
  logic        [63:0] sq_x, sq_y, sq_z;
  logic        [65:0] sum_q;
  logic signed [31:0] plane_q [20];
  logic        [19:0] vld;

  logic signed [31:0] q_sat;
  logic signed [31:0] sphere_dist;
  logic signed [31:0] min_dist;

  // Stages 1-3 of the sphere path plus the plane-distance delay line that keeps it aligned.
  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  // NOTE: pure datapath registers carry no reset; only the valid chain and outputs need one.
  always_ff @(posedge clk) begin
    dx <= sat_sub(bus.pos[95:64], SPHERE_CX);
    dy <= sat_sub(bus.pos[63:32], SPHERE_CY);
    dz <= sat_sub(bus.pos[31:0],  SPHERE_CZ);
    sq_x <= $unsigned(64'(dx) * 64'(dx));
    sq_y <= $unsigned(64'(dy) * 64'(dy));
    sq_z <= $unsigned(64'(dz) * 64'(dz));
    sum_q <= 66'(sq_x) + 66'(sq_y) + 66'(sq_z);
    plane_q[0] <= sat_sub(bus.pos[63:32], PLANE_Y);
    for (int i = 1; i < 20; i++) plane_q[i] <= plane_q[i-1];
  end

  // 17 sqrt stages, two root bits each; the radicand is padded to 68 bits (34 digit pairs).
  for (genvar k = 0; k < 17; k++) begin : g_sqrt
    sqrt_t st_in;
    sqrt_t st_q;
    if (k == 0) begin : g_first
      assign st_in = '{rad: {2'b00, sum_q}, rem: '0, root: '0};
    end else begin : g_next
      assign st_in = g_sqrt[k-1].st_q;
    end

    // Two digit iterations per pipeline stage.
    always_ff @(posedge clk) begin
      st_q <= sqrt_iter(sqrt_iter(st_in));
    end
  end

  // Final-stage arithmetic: clamp the root, offset by the radius, take the nearer surface.
  // NOTE: every variable is assigned on every path, so this stays pure combinational logic.
  always_comb begin
    q_sat       = (g_sqrt[16].st_q.root > 34'h07FFFFFFF) ? 32'sh7FFFFFFF
                                                         : g_sqrt[16].st_q.root[31:0];
    sphere_dist = sat_sub(q_sat, SPHERE_R);
    min_dist    = (sphere_dist < plane_q[19]) ? sphere_dist : plane_q[19];
  end

  // Valid chain and output register; the result holds whenever no valid query arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld                 <= '0;
      bus.out_valid       <= 1'b0;
      bus.closestDistance <= '0;
    end else begin
      vld           <= {vld[18:0], bus.in_valid};
      bus.out_valid <= vld[19];
      if (vld[19]) bus.closestDistance <= min_dist;
    end
  end

endmodule

// File: tb/tb_scene_query.sv
// Scoreboard bench for scene_query: the driver pushes expected results (from a plain
// arithmetic model or known constants) with their due cycle; a monitor pops on out_valid.
module tb_scene_query;

  localparam logic [31:0] CX = 32'h00000000;
  localparam logic [31:0] CY = 32'h01000000;
  localparam logic [31:0] CZ = 32'h06000000;
  localparam logic [31:0] R  = 32'h01000000;
  localparam logic [31:0] PY = 32'h00000000;
  localparam int          LAT = 21;
  localparam longint      MAXV = 64'sh7FFFFFFF;
  localparam longint      MINV = -64'sh80000000;

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] last_out = '0;
  exp_t exp_q[$];

  scene_query_if bus();

  scene_query #(
    .SPHERE_CX(CX), .SPHERE_CY(CY), .SPHERE_CZ(CZ), .SPHERE_R(R), .PLANE_Y(PY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sat32(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // Reference: exact Euclidean distance floor-rooted in Q8.24, min with the plane height.
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
    longint      ddx, ddy, ddz, sphere, plane, qs;
    logic [71:0] s, q, t;
    ddx = sat32(longint'($signed(x)) - longint'($signed(CX)));
    ddy = sat32(longint'($signed(y)) - longint'($signed(CY)));
    ddz = sat32(longint'($signed(z)) - longint'($signed(CZ)));
    s = 72'(ddx * ddx) + 72'(ddy * ddy) + 72'(ddz * ddz);
    q = '0;
    for (int b = 33; b >= 0; b--) begin
      t = q | (72'(1) << b);
      if (t * t <= s) q = t;
    end
    qs     = (q > 72'h7FFFFFFF) ? MAXV : longint'(q);
    sphere = sat32(qs - longint'($signed(R)));
    plane  = sat32(longint'($signed(y)) - longint'($signed(PY)));
    return (sphere < plane) ? 32'(sphere) : 32'(plane);
  endfunction

  function automatic logic [31:0] rnd_coord();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return $urandom_range(0, 32'h10000000) - 32'h08000000;
      default: return $urandom_range(0, 32'h04000000) + 32'h04000000;
    endcase
  endfunction

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                      input logic [31:0] exp);
    @(posedge clk);
    #1;
    bus.pos      = {x, y, z};
    bus.in_valid = 1'b1;
    exp_q.push_back('{val: exp, due: cyc + LAT});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.pos      = {$urandom, $urandom, $urandom};
    end
  endtask

  task automatic send_rand(input int n);
    logic [31:0] x, y, z;
    repeat (n) begin
      if ($urandom_range(0, 9) < 7) begin
        x = rnd_coord();
        y = rnd_coord();
        z = rnd_coord();
        send(x, y, z, model(x, y, z));
      end else begin
        idle(1);
      end
    end
  endtask

  // Monitor: scoreboard pop on every result, hold/reset checks otherwise.
  always @(negedge clk) begin
    if (rst) begin
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_distance", bus.closestDistance, 32'd0);
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("distance", bus.closestDistance, e.val);
        check("latency_cycle", 32'(cyc), 32'(e.due));
        last_out = e.val;
      end
    end else begin
      check("hold_distance", bus.closestDistance, last_out);
    end
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.pos      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("init_out_valid", 32'(bus.out_valid), 32'd0);
    check("init_distance", bus.closestDistance, 32'd0);
    rst = 1'b0;

    // Known points, first one alone so its latency is seen in isolation.
    send(32'h00000000, 32'h01000000, 32'h06000000, 32'hFF000000);
    idle(24);
    send(32'h80000000, 32'h7F000000, 32'h80000000, 32'h7EFFFFFF);
    idle(3);
    // Four back-to-back, then a gap.
    send(32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000);
    send(32'h00000000, 32'h01000000, 32'h00000000, 32'h01000000);
    send(32'h00000000, 32'h04000000, 32'h02000000, 32'h04000000);
    send(32'h00000000, 32'h05000000, 32'h06000000, 32'h03000000);
    idle(25);

    send_rand(150);

    // Reset with a full pipeline and results emerging.
    send_rand(30);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    last_out     = '0;
    #1;
    check("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_reset_distance", bus.closestDistance, 32'd0);
    idle(2);
    rst = 1'b0;

    // First query after release must take exactly the full latency.
    send(32'h00000000, 32'h01000000, 32'h06000000, 32'hFF000000);
    send_rand(100);
    idle(1);

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) check("drain_pending", 32'(exp_q.size()), 32'd0);
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
